// File: rtl/food_placer_pkg.sv
// Shared snake game constants, coordinate type and placer state encoding.
// Used by the food placer, occupancy checker and renderer.
package snake_pkg;

  localparam int COORD_W = 4;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t GRID_MIN = coord_t'(1);
  localparam coord_t GRID_MAX = coord_t'(14);
  localparam logic [3:0] MAX_RETRY = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_X,
    ST_GET_Y,
    ST_QUERY,
    ST_SCAN,
    ST_FULL
  } placer_st_t;

  function automatic logic in_grid(coord_t c);
    return (c >= GRID_MIN) && (c <= GRID_MAX);
  endfunction

endpackage

// File: rtl/food_placer_if.sv
// Snake-body occupancy query port: req/ack with a hit answer.
// master = asks about a cell, slave = answers.
interface food_placer_if;
  import snake_pkg::*;

  logic   occ_req;
  coord_t occ_x;
  coord_t occ_y;
  logic   occ_ack;
  logic   occ_hit;

  modport master (
    output occ_req, occ_x, occ_y,
    input  occ_ack, occ_hit
  );

  modport slave (
    input  occ_req, occ_x, occ_y,
    output occ_ack, occ_hit
  );

endinterface

// File: rtl/food_placer_scan_ctr.sv
// Row-major grid walker for the fallback scan, x fastest.
// wrap is high while sitting on the last cell (GRID_MAX,GRID_MAX).
module food_scan_ctr
  import snake_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   step,
  output coord_t x,
  output coord_t y,
  output logic   wrap
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= GRID_MIN;
      y <= GRID_MIN;
    end else if (load) begin
      x <= GRID_MIN;
      y <= GRID_MIN;
    end else if (step) begin
      if (x == GRID_MAX) begin
        x <= GRID_MIN;
        y <= (y == GRID_MAX) ? GRID_MIN
                             : y + coord_t'(1);
      end else begin
        x <= x + coord_t'(1);
      end
    end
  end

  assign wrap = (x == GRID_MAX) && (y == GRID_MAX);

endmodule

// File: rtl/food_placer.sv
// Snake food placer: random candidates checked for occupancy, scan fallback.
// Define FOOD_AGING_EN to relocate food after AGE_TICKS game ticks.
module food_placer
  import snake_pkg::*;
#(
  parameter int AGE_TICKS = 64
) (
  input  logic   clk,
  input  logic   rst,
  input  coord_t rnd,
  input  logic   spawn_req,
  input  logic   game_tick,
  food_placer_if.master occ,
  output coord_t food_x,
  output coord_t food_y,
  output logic   food_valid,
  output logic   busy,
  output logic   grid_full
);

  placer_st_t state, state_n;
  coord_t     cand_x, cand_y;
  coord_t     scan_x, scan_y;
  logic [3:0] retry;
  logic       pending, req_q, req_n;
  logic       scan_wrap, ack, last_try;
  logic       start, ld_x, ld_y, reject;
  logic       commit, scan_load, scan_step;
  logic       to_full, age_fire;

  food_scan_ctr u_scan (
    .clk  (clk),
    .rst  (rst),
    .load (scan_load),
    .step (scan_step),
    .x    (scan_x),
    .y    (scan_y),
    .wrap (scan_wrap)
  );

  assign ack      = req_q & occ.occ_ack;
  assign last_try = (retry == MAX_RETRY - 4'd1);
  assign busy     = state inside
    {ST_GET_X, ST_GET_Y, ST_QUERY, ST_SCAN};

  assign occ.occ_req = req_q;
  assign occ.occ_x   = (state == ST_SCAN) ? scan_x : cand_x;
  assign occ.occ_y   = (state == ST_SCAN) ? scan_y : cand_y;

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    ld_x      = 1'b0;
    ld_y      = 1'b0;
    reject    = 1'b0;
    commit    = 1'b0;
    scan_load = 1'b0;
    scan_step = 1'b0;
    to_full   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (spawn_req || pending) begin
          start   = 1'b1;
          state_n = ST_GET_X;
        end
      end
      ST_GET_X: begin
        ld_x    = 1'b1;
        state_n = ST_GET_Y;
      end
      ST_GET_Y: begin
        ld_y = 1'b1;
        if (!in_grid(cand_x) || !in_grid(rnd)) begin
          reject    = 1'b1;
          scan_load = last_try;
          state_n   = last_try ? ST_SCAN : ST_GET_X;
        end else begin
          state_n = ST_QUERY;
        end
      end
      ST_QUERY: begin
        if (ack && occ.occ_hit) begin
          reject    = 1'b1;
          scan_load = last_try;
          state_n   = last_try ? ST_SCAN : ST_GET_X;
        end else if (ack) begin
          commit  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (ack && occ.occ_hit) begin
          to_full   = scan_wrap;
          scan_step = !scan_wrap;
          state_n   = scan_wrap ? ST_FULL : ST_SCAN;
        end else if (ack) begin
          commit  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_FULL: state_n = ST_FULL;
      default: state_n = ST_IDLE;
    endcase
    // one idle cycle between scan queries keeps each request a fresh rise
    req_n = (state_n == ST_QUERY || state_n == ST_SCAN) && !ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_q      <= 1'b0;
      cand_x     <= GRID_MIN;
      cand_y     <= GRID_MIN;
      retry      <= '0;
      pending    <= 1'b1;
      food_x     <= GRID_MIN;
      food_y     <= GRID_MIN;
      food_valid <= 1'b0;
      grid_full  <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= req_n;
      if (ld_x) cand_x <= rnd;
      if (ld_y) cand_y <= rnd;
      if (reject) retry <= retry + 4'd1;
      else if (commit) retry <= '0;
      if (start) pending <= 1'b0;
      else if ((spawn_req && busy) || age_fire) pending <= 1'b1;
      if (start || to_full) food_valid <= 1'b0;
      else if (commit) food_valid <= 1'b1;
      if (commit) begin
        food_x <= (state == ST_SCAN) ? scan_x : cand_x;
        food_y <= (state == ST_SCAN) ? scan_y : cand_y;
      end
      if (to_full) grid_full <= 1'b1;
    end
  end

`ifdef FOOD_AGING_EN
  localparam int AW = $clog2(AGE_TICKS + 1);
  logic [AW-1:0] age;

  assign age_fire = (state == ST_IDLE) && food_valid && game_tick
                    && (age == AW'(AGE_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) age <= '0;
    else if (commit || age_fire) age <= '0;
    else if (state == ST_IDLE && food_valid && game_tick)
      age <= age + AW'(1);
  end
`else
  logic unused_aging;
  assign unused_aging = game_tick | (AGE_TICKS == 0);
  assign age_fire = 1'b0;
`endif

endmodule
